// File: rtl/perm_seq_if.sv
// Handshake and control bundle between the Keccak sequencer, the NoC side and the round datapath.
// master = sequencer side, slave = NoC/datapath side.
interface perm_seq_if #(
    parameter int RIDX_W = 5
);
    logic              pushin;
    logic              firstin;
    logic              stopin;
    logic              ld_wr;
    logic [2:0]        ld_x;
    logic [2:0]        ld_y;
    logic              rnd_start;
    logic [RIDX_W-1:0] rnd_idx;
    logic              rnd_done;
    logic              src_bank;
    logic              dst_bank;
    logic              pushout;
    logic              firstout;
    logic              stopout;
    logic [2:0]        ul_x;
    logic [2:0]        ul_y;
    logic              busy;
    logic              err;

    modport master (
        input  pushin, firstin, rnd_done, stopout,
        output stopin, ld_wr, ld_x, ld_y, rnd_start, rnd_idx, src_bank, dst_bank,
               pushout, firstout, ul_x, ul_y, busy, err
    );

    modport slave (
        output pushin, firstin, rnd_done, stopout,
        input  stopin, ld_wr, ld_x, ld_y, rnd_start, rnd_idx, src_bank, dst_bank,
               pushout, firstout, ul_x, ul_y, busy, err
    );
endinterface

// File: rtl/perm_seq.sv
// Keccak-f[1600] sequencer: loads 25 lanes into bank 0, runs NROUNDS ping-pong rounds, streams the result.
// state  | meaning
// IDLE   | waiting for a lane flagged firstin
// LOAD   | writing lanes 1..24 into bank 0
// RSTART | one-cycle round start pulse
// RWAIT  | waiting for the datapath to finish the round
// UNLOAD | presenting result lanes from bank 0 under backpressure
module perm_seq #(
    parameter int NROUNDS = 24,
    parameter int RIDX_W  = 5
) (
    input  logic       clk,
    input  logic       reset,
    perm_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RSTART, RWAIT, UNLOAD} state_t;

    localparam logic [RIDX_W-1:0] LAST_RND = RIDX_W'(NROUNDS - 1);

    state_t            state_q;
    logic [2:0]        x_q;
    logic [2:0]        y_q;
    logic [2:0]        x_d;
    logic [2:0]        y_d;
    logic [RIDX_W-1:0] rnd_idx_q;
    logic              src_q;
    logic              stopin_q;
    logic              rnd_start_q;
    logic              pushout_q;
    logic              firstout_q;
    logic              busy_q;
    logic              err_q;
    logic              last_lane;
    logic              resync;

    always_comb begin
        x_d = x_q + 3'd1;
        y_d = y_q;
        if (x_q == 3'd4) begin
            x_d = 3'd0;
            y_d = y_q + 3'd1;
        end
    end

    assign last_lane = (x_q == 3'd4) && (y_q == 3'd4);
    assign resync    = bus.pushin && bus.firstin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= 3'd0;
            y_q         <= 3'd0;
            rnd_idx_q   <= '0;
            src_q       <= 1'b0;
            stopin_q    <= 1'b0;
            rnd_start_q <= 1'b0;
            pushout_q   <= 1'b0;
            firstout_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q       <= 1'b0;
            rnd_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.pushin) begin
                        if (bus.firstin) begin
                            state_q <= LOAD;
                            x_q     <= 3'd1;
                            y_q     <= 3'd0;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.pushin) begin
                        // A fresh firstin restarts the block; this lane becomes lane 0.
                        if (bus.firstin) begin
                            x_q   <= 3'd1;
                            y_q   <= 3'd0;
                            err_q <= 1'b1;
                        end else if (last_lane) begin
                            state_q     <= RSTART;
                            x_q         <= 3'd0;
                            y_q         <= 3'd0;
                            rnd_idx_q   <= '0;
                            src_q       <= 1'b0;
                            stopin_q    <= 1'b1;
                            rnd_start_q <= 1'b1;
                        end else begin
                            x_q <= x_d;
                            y_q <= y_d;
                        end
                    end
                end
                RSTART: begin
                    state_q <= RWAIT;
                end
                RWAIT: begin
                    if (bus.rnd_done) begin
                        if (rnd_idx_q == LAST_RND) begin
                            state_q    <= UNLOAD;
                            pushout_q  <= 1'b1;
                            firstout_q <= 1'b1;
                        end else begin
                            state_q     <= RSTART;
                            rnd_idx_q   <= rnd_idx_q + 1'b1;
                            src_q       <= ~src_q;
                            rnd_start_q <= 1'b1;
                        end
                    end
                end
                UNLOAD: begin
                    if (!bus.stopout) begin
                        firstout_q <= 1'b0;
                        if (last_lane) begin
                            state_q   <= IDLE;
                            x_q       <= 3'd0;
                            y_q       <= 3'd0;
                            pushout_q <= 1'b0;
                            stopin_q  <= 1'b0;
                            busy_q    <= 1'b0;
                        end else begin
                            x_q <= x_d;
                            y_q <= y_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ld_wr     = ((state_q == IDLE) && resync) || ((state_q == LOAD) && bus.pushin);
    assign bus.ld_x      = ((state_q == LOAD) && !resync) ? x_q : 3'd0;
    assign bus.ld_y      = ((state_q == LOAD) && !resync) ? y_q : 3'd0;
    assign bus.ul_x      = pushout_q ? x_q : 3'd0;
    assign bus.ul_y      = pushout_q ? y_q : 3'd0;
    assign bus.stopin    = stopin_q;
    assign bus.rnd_start = rnd_start_q;
    assign bus.rnd_idx   = rnd_idx_q;
    assign bus.src_bank  = src_q;
    assign bus.dst_bank  = ~src_q;
    assign bus.pushout   = pushout_q;
    assign bus.firstout  = firstout_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_perm_seq.sv
// Randomized bench for perm_seq: expected lane order, round sequence and unload stream come from block-level rules.
module tb_perm_seq;
    localparam int NR = 24;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    perm_seq_if #(.RIDX_W(RW)) bus_if ();
    perm_seq #(.NROUNDS(NR), .RIDX_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus_if));

    typedef struct {int idx; int src;} start_t;
    typedef struct {int lane; int first;} out_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     ld_q[$];
    start_t start_q[$];
    out_t   out_q[$];
    int     cyc = 0;
    int     last_done_cyc = 0;
    int     pend = 0;
    int     done_dly = 3;
    int     err_cnt = 0;
    bit     echo_same = 1'b0;
    bit     prev_hold = 1'b0;
    bit     prev_err = 1'b0;
    int     prev_lane = 0;
    int     prev_first = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Round datapath stand-in: echo rnd_done done_dly cycles after each rnd_start.
    initial begin
        bus_if.rnd_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.rnd_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) bus_if.rnd_done = 1'b1;
            end
            if (echo_same && bus_if.rnd_start) bus_if.rnd_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.ld_wr) begin
                chk_eq("ldwr_accept", 32'(bus_if.pushin && !bus_if.stopin), 1);
                ld_q.push_back(int'(bus_if.ld_x) + 5 * int'(bus_if.ld_y));
            end
            if (bus_if.rnd_start) begin
                chk_eq("start_stall", 32'(bus_if.stopin), 1);
                chk_eq("bank_cmpl", 32'(bus_if.src_bank ^ bus_if.dst_bank), 1);
                if (start_q.size() > 0) chk_eq("rnd_latency", cyc - last_done_cyc, 1);
                start_q.push_back('{idx: int'(bus_if.rnd_idx), src: int'(bus_if.src_bank)});
                pend = done_dly;
            end
            if (bus_if.rnd_done && !bus_if.rnd_start) last_done_cyc = cyc;
            if (prev_hold) begin
                chk_eq("hold_push", 32'(bus_if.pushout), 1);
                chk_eq("hold_lane", int'(bus_if.ul_x) + 5 * int'(bus_if.ul_y), prev_lane);
                chk_eq("hold_first", 32'(bus_if.firstout), prev_first);
            end
            if (bus_if.pushout) begin
                chk_eq("out_stall", 32'(bus_if.stopin), 1);
                if (!bus_if.stopout)
                    out_q.push_back('{lane: int'(bus_if.ul_x) + 5 * int'(bus_if.ul_y),
                                      first: int'(bus_if.firstout)});
            end
            if (bus_if.err) begin
                chk_eq("err_consec", 32'(prev_err), 0);
                err_cnt++;
            end
            prev_hold  = bus_if.pushout && bus_if.stopout;
            prev_lane  = int'(bus_if.ul_x) + 5 * int'(bus_if.ul_y);
            prev_first = int'(bus_if.firstout);
            prev_err   = bus_if.err;
        end else begin
            prev_hold = 1'b0;
            prev_err  = 1'b0;
        end
    end

    task automatic push_lane(input bit first);
        bus_if.pushin  = 1'b1;
        bus_if.firstin = first;
        @(negedge clk);
        chk_eq("stopin_load", 32'(bus_if.stopin), 0);
        @(posedge clk);
        #1;
        bus_if.pushin  = 1'b0;
        bus_if.firstin = 1'b0;
    endtask

    task automatic idle_err();
        err_cnt = 0;
        ld_q.delete();
        bus_if.pushin  = 1'b1;
        bus_if.firstin = 1'b0;
        @(negedge clk);
        chk_eq("idle_ldwr", 32'(bus_if.ld_wr), 0);
        chk_eq("idle_stopin", 32'(bus_if.stopin), 0);
        @(posedge clk);
        #1;
        bus_if.pushin = 1'b0;
        @(negedge clk);
        chk_eq("idle_err", 32'(bus_if.err), 1);
        chk_eq("idle_busy", 32'(bus_if.busy), 0);
        @(negedge clk);
        chk_eq("idle_err_once", 32'(bus_if.err), 0);
        chk_eq("idle_err_cnt", err_cnt, 1);
        chk_eq("idle_noload", ld_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // resync_at > 0 reasserts firstin at that load lane; abort_rnd >= 0 resets in RWAIT of that round.
    task automatic run_block(input int resync_at, input int gap_pct, input int stall_pct, input int abort_rnd);
        int exp_ld[$];
        bit done;
        ld_q.delete();
        start_q.delete();
        out_q.delete();
        err_cnt = 0;
        for (int i = 0; i < resync_at; i++) exp_ld.push_back(i);
        for (int i = 0; i < 25; i++) exp_ld.push_back(i);
        for (int k = 0; k < exp_ld.size(); k++) begin
            while ($urandom_range(99) < gap_pct) begin
                @(posedge clk);
                #1;
            end
            push_lane(exp_ld[k] == 0);
        end
        chk_eq("no_early_start", start_q.size(), 0);
        chk_eq("stall_after_load", 32'(bus_if.stopin), 1);
        chk_eq("ld_count", ld_q.size(), exp_ld.size());
        for (int k = 0; k < exp_ld.size() && k < ld_q.size(); k++)
            chk_eq("ld_lane", ld_q[k], exp_ld[k]);

        if (abort_rnd >= 0) begin
            done = 1'b0;
            for (int t = 0; t < 2000; t++) begin
                if (start_q.size() > abort_rnd) begin
                    done = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            chk_eq("abort_reach", 32'(done), 1);
            chk_eq("abort_idx", 32'(bus_if.rnd_idx), abort_rnd);
            chk_eq("abort_busy", 32'(bus_if.busy), 1);
            #1;
            reset = 1'b1;
            #1;
            chk_eq("abort_pushout", 32'(bus_if.pushout), 0);
            chk_eq("abort_busy_clr", 32'(bus_if.busy), 0);
            chk_eq("abort_rnd_idx", 32'(bus_if.rnd_idx), 0);
            chk_eq("abort_stopin", 32'(bus_if.stopin), 0);
            chk_eq("abort_src", 32'(bus_if.src_bank), 0);
            pend = 0;
            @(posedge clk);
            #1;
            reset = 1'b0;
            return;
        end

        done = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(posedge clk);
            #1;
            if (out_q.size() >= 25) begin
                done = 1'b1;
                break;
            end
            bus_if.stopout = ($urandom_range(99) < stall_pct);
        end
        bus_if.stopout = 1'b0;
        chk_eq("unload_done", 32'(done), 1);
        @(negedge clk);
        chk_eq("end_pushout", 32'(bus_if.pushout), 0);
        chk_eq("end_stopin", 32'(bus_if.stopin), 0);
        chk_eq("end_busy", 32'(bus_if.busy), 0);
        chk_eq("rnd_count", start_q.size(), NR);
        for (int k = 0; k < start_q.size(); k++) begin
            chk_eq("rnd_idx", start_q[k].idx, k);
            chk_eq("rnd_src", start_q[k].src, k % 2);
        end
        chk_eq("out_count", out_q.size(), 25);
        for (int k = 0; k < out_q.size(); k++) begin
            chk_eq("out_lane", out_q[k].lane, k);
            chk_eq("out_first", out_q[k].first, (k == 0) ? 1 : 0);
        end
        chk_eq("err_count", err_cnt, (resync_at > 0) ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        bus_if.pushin  = 1'b0;
        bus_if.firstin = 1'b0;
        bus_if.stopout = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_stopin", 32'(bus_if.stopin), 0);
        chk_eq("rst_ld_wr", 32'(bus_if.ld_wr), 0);
        chk_eq("rst_rnd_start", 32'(bus_if.rnd_start), 0);
        chk_eq("rst_pushout", 32'(bus_if.pushout), 0);
        chk_eq("rst_firstout", 32'(bus_if.firstout), 0);
        chk_eq("rst_busy", 32'(bus_if.busy), 0);
        chk_eq("rst_err", 32'(bus_if.err), 0);
        chk_eq("rst_addr", {20'd0, bus_if.ld_x, bus_if.ld_y, bus_if.ul_x, bus_if.ul_y}, 0);
        chk_eq("rst_rnd_idx", 32'(bus_if.rnd_idx), 0);
        chk_eq("rst_src", 32'(bus_if.src_bank), 0);
        chk_eq("rst_dst", 32'(bus_if.dst_bank), 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_block(0, 0, 0, -1);
        run_block(0, 30, 50, -1);
        idle_err();
        run_block(0, 20, 25, -1);
        run_block(10, 0, 0, -1);
        run_block(0, 0, 0, 7);
        run_block(0, 10, 40, -1);
        echo_same = 1'b1;
        run_block(0, 0, 30, -1);
        echo_same = 1'b0;
        for (int r = 0; r < 2; r++)
            run_block(int'($urandom_range(1, 24)), 20, 30, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/perm_seq.md
Name: perm_seq

Overview:
- Sequencer for the Keccak-f[1600] permutation datapath that sits between the NoC interface and the lane memories.
- Loads the 25 input lanes of a block into a 5x5x64 lane memory bank.
- Steps the round datapath through NROUNDS rounds, ping-ponging between two banks, then streams the 25 result lanes back to the NoC interface under backpressure.
- Drives only control and addresses. Lane data muxing stays in the datapath, which is steered by src_bank/dst_bank and the address outputs.

Parameters:
- NROUNDS, 24: rounds per permutation. Must be even and >= 2, so the result lands in bank 0.
- RIDX_W, 5: width of rnd_idx. Must satisfy 2**RIDX_W >= NROUNDS.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- pushin  in  1  upstream lane valid.
- firstin  in  1  marks lane 0 of a block; qualified by pushin.
- stopin  out  1  upstream stall; a lane is accepted when pushin=1 and stopin=0.
- ld_wr  out  1  bank-0 write strobe for the load lane.
- ld_x  out  3  load lane x.
- ld_y  out  3  load lane y.
- rnd_start  out  1  one-cycle pulse that starts one round.
- rnd_idx  out  RIDX_W  current round number, used for iota constant selection.
- rnd_done  in  1  one-cycle pulse from the round datapath when the round has been written.
- src_bank  out  1  bank the round reads from.
- dst_bank  out  1  bank the round writes to (always the complement of src_bank).
- pushout  out  1  result lane valid.
- firstout  out  1  marks result lane 0.
- stopout  in  1  downstream stall; a lane is accepted when pushout=1 and stopout=0.
- ul_x  out  3  unload read lane x (bank 0, combinational read; data valid in the same cycle as pushout).
- ul_y  out  3  unload read lane y.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Lane index i = 5*y + x, i in 0..24; x varies fastest. The same mapping applies to ld_x/ld_y and ul_x/ul_y.
- Reset, asynchronous:
  - state = IDLE; lane counter = 0; rnd_idx = 0; src_bank = 0; dst_bank = 1.
  - stopin, ld_wr, rnd_start, pushout, firstout, busy, err all = 0.
  - ld_x, ld_y, ul_x, ul_y all = 0.
  - Reset mid-block discards the block; no partial output is produced.
- IDLE:
  - stopin = 0.
  - pushin & firstin: ld_wr = 1 at lane 0 (combinational from pushin & firstin & lane-0 address); go to LOAD with counter = 1.
  - pushin & !firstin: lane dropped, err pulses the next cycle, stay in IDLE.
- LOAD:
  - stopin = 0; ld_wr = pushin; address = counter.
  - pushin & firstin: resynchronize. The lane is written as lane 0, counter = 1, err pulses.
  - Accepting lane 24: go to RSTART with rnd_idx = 0, src_bank = 0, dst_bank = 1.
  - Cycles without pushin hold the counter.
- RSTART:
  - stopin = 1; rnd_start = 1 for exactly this one cycle; go to RWAIT.
  - A rnd_done arriving during RSTART is ignored.
- RWAIT:
  - stopin = 1; wait indefinitely for rnd_done.
  - On rnd_done with rnd_idx < NROUNDS-1: rnd_idx increments, src_bank and dst_bank swap, go to RSTART.
  - On rnd_done with rnd_idx = NROUNDS-1: go to UNLOAD with counter = 0.
- Round-cycle latency from rnd_done to the next rnd_start is exactly 1 cycle.
- UNLOAD:
  - stopin = 1; pushout = 1; ul address = counter; firstout = (counter == 0).
  - When stopout = 0: counter increments. The accepted lane 24 returns to IDLE (pushout = 0 next cycle).
  - When stopout = 1: address, pushout and firstout hold stable.
- Upstream is stalled from the cycle after lane 24 is accepted until the cycle after the last result lane is accepted.
- The minimum block period is 25 (load) + 2*NROUNDS plus round-datapath latency + 25 (unload) cycles.
- busy = (state != IDLE). err is registered and never asserted for two consecutive cycles without a new cause.

Test Plan:
1. Reset, then lanes 0..24 on consecutive cycles (firstin on lane 0), rnd_done echoed 3 cycles after each rnd_start -> ld_wr high 25 cycles with (x,y) running (0,0)..(4,4); exactly 24 rnd_start pulses with rnd_idx 0..23; src_bank alternates 0,1,0,...; then 25 pushout lanes, firstout only on the first; pushout low after lane 24.
2. Random stopout (50%) during unload -> ul_x/ul_y/firstout stable while stalled; exactly 25 accepts in order 0..24; stopin stays 1 until after the last accept.
3. pushin without firstin in IDLE -> err pulses once, no ld_wr, state stays IDLE; a following proper block completes normally.
4. firstin reasserted at load lane 10 -> err pulse, that lane written at (0,0); 24 further lanes are needed before rnd_start.
5. Reset asserted in RWAIT at rnd_idx = 7 -> same-cycle async clear: pushout = 0, busy = 0, rnd_idx = 0, stopin = 0; the next block runs a full 24 rounds.
6. rnd_done asserted in the same cycle as rnd_start -> ignored; rnd_idx does not advance until a later rnd_done arrives in RWAIT.
